// File: rtl/gafe_pkg.sv
// Shared types and constants for the GAFE OTA scan sequencer.
package gafe_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SETTLE,
    SAMPLE,
    OUTPUT
  } state_e;

endpackage

// File: rtl/gafe_sync2.sv
// Reset-to-zero flop chain that brings one asynchronous comparator bit into the clk domain.
module gafe_sync2
  import gafe_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gafe_ota_scan_ctrl.sv
// Scans masked OTA channels: power one, settle, count comparator ones, return result.
// Optional GAFE_CHOP_EN adds ota_chop and inverts samples taken while it is high.
module gafe_ota_scan_ctrl
  import gafe_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CH_W     = 2,
  parameter int unsigned SETTLE_W = 8,
  parameter int unsigned SAMPLE_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                continuous,
  input  logic                stop,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [SAMPLE_W-1:0] num_samples,
  input  logic [NUM_CH-1:0]   cmp_in,
  output logic [NUM_CH-1:0]   ota_en,
`ifdef GAFE_CHOP_EN
  output logic                ota_chop,
`endif
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [CH_W-1:0]     res_ch,
  output logic [SAMPLE_W-1:0] res_count
);

  localparam int unsigned TMR_W = (SETTLE_W + 1 > SAMPLE_W) ? SETTLE_W + 1 : SAMPLE_W;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [SAMPLE_W-1:0] nsamp_q, nsamp_d;
  logic                cont_q, cont_d;
  logic                stop_pend_q, stop_pend_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [SAMPLE_W-1:0] count_q, count_d;
  logic [NUM_CH-1:0]   ota_en_q, ota_en_d;
  logic                busy_q, busy_d;
  logic                res_valid_q, res_valid_d;
  logic                chop_q, chop_d;
  logic [NUM_CH-1:0]   cmp_sync;
  logic                samp_bit;

  // cmp_in and ota_en cross into/out of the analog macro: clkbuf_inhibit nets.
  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_sync
    gafe_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (cmp_in[g]),
      .q     (cmp_sync[g])
    );
  end

  // Lowest set bit at or above p, else lowest set bit overall.
  function automatic logic [CH_W-1:0] pick_ch(input logic [NUM_CH-1:0] m,
                                               input logic [CH_W-1:0]   p);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (m[i]) r = CH_W'(i);
    end
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (m[i] && (i >= int'(p))) r = CH_W'(i);
    end
    return r;
  endfunction

  function automatic logic has_above(input logic [NUM_CH-1:0] m,
                                     input logic [CH_W-1:0]   c);
    logic f;
    f = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (m[i] && (i > int'(c))) f = 1'b1;
    end
    return f;
  endfunction

`ifdef GAFE_CHOP_EN
  assign samp_bit = cmp_sync[ch_q] ^ chop_q;
`else
  assign samp_bit = cmp_sync[ch_q];
`endif

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    ptr_d       = ptr_q;
    mask_d      = mask_q;
    settle_d    = settle_q;
    nsamp_d     = nsamp_q;
    cont_d      = cont_q;
    stop_pend_d = stop_pend_q;
    timer_d     = timer_q;
    count_d     = count_q;
    ota_en_d    = ota_en_q;
    busy_d      = busy_q;
    res_valid_d = res_valid_q;
    chop_d      = chop_q;

    if ((state_q != IDLE) && stop) stop_pend_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start && (|ch_mask)) begin
          mask_d      = ch_mask;
          settle_d    = settle_cycles;
          nsamp_d     = num_samples;
          cont_d      = continuous;
          ptr_d       = '0;
          stop_pend_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        ch_d           = pick_ch(mask_q, ptr_q);
        ota_en_d       = '0;
        ota_en_d[ch_d] = 1'b1;
        timer_d        = TMR_W'(settle_q) + TMR_W'(1);
        count_d        = '0;
        state_d        = SETTLE;
      end
      SETTLE: begin
        if (timer_q == '0) begin
          timer_d = (nsamp_q == '0) ? '0 : TMR_W'(nsamp_q - SAMPLE_W'(1));
          chop_d  = 1'b0;
          state_d = SAMPLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      SAMPLE: begin
        if (samp_bit && (count_q != '1)) count_d = count_q + SAMPLE_W'(1);
        chop_d = ~chop_q;
        if (timer_q == '0) begin
          chop_d      = 1'b0;
          res_valid_d = 1'b1;
          state_d     = OUTPUT;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      OUTPUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          ota_en_d    = '0;
          ptr_d       = (int'(ch_q) == int'(NUM_CH) - 1) ? '0 : ch_q + CH_W'(1);
          if ((!has_above(mask_q, ch_q) && !cont_q) || stop_pend_q || stop) begin
            busy_d      = 1'b0;
            stop_pend_d = 1'b0;
            state_d     = IDLE;
          end else begin
            state_d = SELECT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      ptr_q       <= '0;
      mask_q      <= '0;
      settle_q    <= '0;
      nsamp_q     <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      timer_q     <= '0;
      count_q     <= '0;
      ota_en_q    <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      chop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      ptr_q       <= ptr_d;
      mask_q      <= mask_d;
      settle_q    <= settle_d;
      nsamp_q     <= nsamp_d;
      cont_q      <= cont_d;
      stop_pend_q <= stop_pend_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
      ota_en_q    <= ota_en_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      chop_q      <= chop_d;
    end
  end

  assign ota_en    = ota_en_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_ch    = ch_q;
  assign res_count = count_q;
`ifdef GAFE_CHOP_EN
  assign ota_chop  = chop_q;
`else
  logic unused_chop;
  assign unused_chop = chop_q;
`endif

endmodule

// File: tb/tb_gafe_ota_scan_ctrl.sv
// Directed bench for gafe_ota_scan_ctrl; expectations follow GAFE_CHOP_EN when defined.
module tb_gafe_ota_scan_ctrl;

  localparam int NUM_CH   = 4;
  localparam int CH_W     = 2;
  localparam int SETTLE_W = 8;
  localparam int SAMPLE_W = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                continuous = 1'b0;
  logic                stop = 1'b0;
  logic [NUM_CH-1:0]   ch_mask = '0;
  logic [SETTLE_W-1:0] settle_cycles = '0;
  logic [SAMPLE_W-1:0] num_samples = '0;
  logic [NUM_CH-1:0]   cmp_in = '0;
  logic                res_ready = 1'b0;
  logic [NUM_CH-1:0]   ota_en;
  logic                busy;
  logic                res_valid;
  logic [CH_W-1:0]     res_ch;
  logic [SAMPLE_W-1:0] res_count;
`ifdef GAFE_CHOP_EN
  logic                ota_chop;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;
  bit seen;

  gafe_ota_scan_ctrl #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .SETTLE_W(SETTLE_W), .SAMPLE_W(SAMPLE_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .continuous    (continuous),
    .stop          (stop),
    .ch_mask       (ch_mask),
    .settle_cycles (settle_cycles),
    .num_samples   (num_samples),
    .cmp_in        (cmp_in),
    .ota_en        (ota_en),
`ifdef GAFE_CHOP_EN
    .ota_chop      (ota_chop),
`endif
    .busy          (busy),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_ch        (res_ch),
    .res_count     (res_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected count for a constant comparator level c over n samples.
  function automatic int exp_count(input int n, input bit c);
    int ns;
    int k;
    bit s;
    ns = (n == 0) ? 1 : n;
    k  = 0;
    for (int i = 0; i < ns; i++) begin
      s = c;
`ifdef GAFE_CHOP_EN
      if ((i % 2) == 1) s = ~s;
`endif
      if (s && (k < 15)) k++;
    end
    return k;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [3:0] m, input logic c, input int s, input int n);
    ch_mask       = m;
    continuous    = c;
    settle_cycles = SETTLE_W'(s);
    num_samples   = SAMPLE_W'(n);
    start         = 1'b1;
    @(negedge clk);
    start         = 1'b0;
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while ((res_valid !== 1'b1) && (c < 300)) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    // 1: reset values, then start with an empty mask
    cmp_in = 4'b0010;
    repeat (2) @(negedge clk);
    chk("rst_ota_en", 32'(ota_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid", 32'(res_valid), 32'h0);
    chk("rst_ch", 32'(res_ch), 32'h0);
    chk("rst_count", 32'(res_count), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(4'b0000, 1'b0, 3, 8);
    seen = 1'b0;
    repeat (5) begin
      if (busy !== 1'b0 || res_valid !== 1'b0 || ota_en !== '0) seen = 1'b1;
      @(negedge clk);
    end
    chk("empty_mask_ignored", 32'(seen), 32'h0);

    // 2: single-shot over channels 1 and 3
    res_ready = 1'b1;
    do_start(4'b1010, 1'b0, 3, 8);
    chk("ss_busy", 32'(busy), 32'h1);
    wait_valid(cyc);
    chk("ss_lat0", 32'(cyc), 32'd14);
    chk("ss_ch0", 32'(res_ch), 32'd1);
    chk("ss_cnt0", 32'(res_count), 32'(exp_count(8, 1'b1)));
    chk("ss_ota0", 32'(ota_en), 32'h2);
    @(negedge clk);
    chk("ss_valid_drop", 32'(res_valid), 32'h0);
    wait_valid(cyc);
    chk("ss_lat1", 32'(cyc), 32'd14);
    chk("ss_ch1", 32'(res_ch), 32'd3);
    chk("ss_cnt1", 32'(res_count), 32'(exp_count(8, 1'b0)));
    chk("ss_ota1", 32'(ota_en), 32'h8);
    @(negedge clk);
    chk("ss_busy_end", 32'(busy), 32'h0);
    chk("ss_ota_end", 32'(ota_en), 32'h0);

    // 3: backpressure holds the result stable
    res_ready = 1'b0;
    do_start(4'b1010, 1'b0, 0, 2);
    wait_valid(cyc);
    chk("bp_lat", 32'(cyc), 32'd5);
    repeat (20) begin
      @(negedge clk);
      chk("bp_valid", 32'(res_valid), 32'h1);
      chk("bp_ch", 32'(res_ch), 32'd1);
      chk("bp_cnt", 32'(res_count), 32'(exp_count(2, 1'b1)));
      chk("bp_ota", 32'(ota_en), 32'h2);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_handshake", 32'(res_valid), 32'h0);
    wait_valid(cyc);
    chk("bp_next_ch", 32'(res_ch), 32'd3);
    chk("bp_next_cnt", 32'(res_count), 32'(exp_count(2, 1'b0)));
    @(negedge clk);
    chk("bp_idle", 32'(busy), 32'h0);

    // 4: continuous single channel, then stop during SETTLE
    cmp_in = 4'b0001;
    do_start(4'b0001, 1'b1, 3, 4);
    repeat (2) begin
      wait_valid(cyc);
      chk("ct_ch", 32'(res_ch), 32'd0);
      chk("ct_cnt", 32'(res_count), 32'(exp_count(4, 1'b1)));
      @(negedge clk);
      chk("ct_busy", 32'(busy), 32'h1);
    end
    repeat (2) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_valid(cyc);
    chk("ct_last_ch", 32'(res_ch), 32'd0);
    chk("ct_last_cnt", 32'(res_count), 32'(exp_count(4, 1'b1)));
    @(negedge clk);
    chk("ct_stop_busy", 32'(busy), 32'h0);
    chk("ct_stop_ota", 32'(ota_en), 32'h0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    chk("ct_no_more", 32'(seen), 32'h0);

    // 5: saturation-range count and zero samples
    cmp_in = 4'b1111;
    do_start(4'b0001, 1'b0, 1, 15);
    wait_valid(cyc);
    chk("sat_cnt", 32'(res_count), 32'(exp_count(15, 1'b1)));
    @(negedge clk);
    do_start(4'b0001, 1'b0, 1, 0);
    wait_valid(cyc);
    chk("zero_lat", 32'(cyc), 32'd5);
    chk("zero_cnt", 32'(res_count), 32'd1);
    @(negedge clk);

    // 6: asynchronous reset mid-SAMPLE, then rescan from the lowest bit
    do_start(4'b0110, 1'b0, 0, 8);
    repeat (5) @(negedge clk);
    chk("mr_ota_pre", 32'(ota_en), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("mr_ota", 32'(ota_en), 32'h0);
    chk("mr_valid", 32'(res_valid), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(4'b0110, 1'b0, 0, 8);
    wait_valid(cyc);
    chk("mr_lat", 32'(cyc), 32'd11);
    chk("mr_ch", 32'(res_ch), 32'd1);
    chk("mr_cnt", 32'(res_count), 32'(exp_count(8, 1'b1)));
    @(negedge clk);
    wait_valid(cyc);
    chk("mr_ch2", 32'(res_ch), 32'd2);
    @(negedge clk);
    chk("mr_idle", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
